adc_capture_window: RTL
=======================

# adc_capture_window

Acquisition sequencer in the ADC unit, directly downstream of the trigger synchronizer. It consumes the single-cycle trigger pulse that the synchronizer produces in the `clk1` domain. On each accepted pulse it waits a programmable pre-capture delay, then streams a programmable number of ADC samples into a sample buffer as a write-enable/address/data sequence, and signals completion with a one-cycle `done` pulse. Triggers that arrive while a window is in progress are rejected and can optionally be counted.

## Interface
Parameters:
- `DATA_W`, 12: ADC sample width.
- `ADDR_W`, 10: buffer address width; also the width of the window length.
- `DLY_W`, 8: delay counter width.

Ports:
- `clk1`  in  1: single clock, rising edge.
- `rstb`  in  1: reset, asynchronous, active-low.
- `trig`  in  1: single-cycle start pulse from the trigger synchronizer.
- `delay`  in  DLY_W: pre-capture delay in cycles; sampled on trigger acceptance.
- `length`  in  ADDR_W: number of samples to capture; sampled on trigger acceptance.
- `adc_data`  in  DATA_W: ADC sample stream, valid every cycle.
- `wr_en`  out  1: buffer write strobe.
- `wr_addr`  out  ADDR_W: buffer write address.
- `wr_data`  out  DATA_W: buffer write data.
- `busy`  out  1: high while a window is in progress.
- `done`  out  1: one-cycle pulse at the end of the window.
- `lost_cnt`  out  8: rejected-trigger count; present only with the macro (see Configuration).

## Operation
- States are `IDLE`, `DELAY`, `CAPTURE` and `DONE`.
- **IDLE:**
  - `trig`=1 latches `delay` into `dly_cnt` and `length` into `len_q`.
  - Next state is `DELAY` if `delay`≠0, otherwise `CAPTURE`.
  - If `length`=0 the next state is `DONE`, and this overrides the choice above.
- **DELAY:**
  - `dly_cnt` decrements once per cycle.
  - The state moves to `CAPTURE` in the cycle in which `dly_cnt` reaches 1.
- **CAPTURE:**
  - Each cycle: `wr_en`=1, `wr_data`=`adc_data` registered on the same edge, `wr_addr`=sample index.
  - The sample index starts at 0 and increments by 1 per write.
  - After `len_q` writes the state moves to `DONE`.
  - `len_q` counts up to 2^ADDR_W−1, so the address never wraps.
- **DONE:** `done`=1 for one cycle, then the state returns to `IDLE`.
- **Trigger rejection:** `trig` is ignored in every state except `IDLE`; each ignored pulse is a lost trigger.
- **Outputs:**
  - All outputs are registered.
  - `busy` = (state≠`IDLE`).
  - `wr_addr` holds its last value outside `CAPTURE`.
- **Reset:**
  - All outputs reset to 0 and the state resets to `IDLE`.
  - A reset asserted mid-window aborts the window immediately: no `done`, and `wr_en` drops asynchronously.

## Timing
- Reference point: `trig` is accepted at edge T, with latched delay D and length L≥1.
- `busy` is high from T+1 through T+D+L+1 inclusive.
- `wr_en` is high on cycles T+D+1 … T+D+L, with `wr_addr` = 0 … L−1.
- The sample written at cycle T+D+1+k is `adc_data` present at edge T+D+k.
- `done` is high on cycle T+D+L+1.
- The earliest next accepted `trig` is at edge T+D+L+2.
- With L=0: `done` is high at T+1, `busy` is high for exactly 1 cycle, and there are no writes.
- Back-to-back windows therefore have a minimum gap of 1 idle cycle after `done`.

## Configuration
- Macro: `ADC_CAPTURE_LOST_CNT_EN`.
- **Defined:**
  - `lost_cnt` increments on every rejected `trig`, saturating at 255.
  - It is cleared only by reset.
  - A `trig` that coincides with the `DONE` cycle counts as lost.
- **Undefined:** the `lost_cnt` port and its logic are absent; rejected triggers are silently dropped.

## Structure
- The shared ADC-unit package holds:
  - the state encoding for `IDLE`/`DELAY`/`CAPTURE`/`DONE`;
  - the default widths `DATA_W`, `ADDR_W` and `DLY_W`;
  - the saturation constant 8'hFF.
- One natural sub-module, `adc_win_counter`: a loadable down-counter with a terminal-count flag. It is instantiated twice, once for the delay and once for the length.
- The FSM and the output registers stay in the top module.

## Test plan
- **Basic window:** `delay`=3, `length`=4, pulse `trig` at T, with `adc_data` ramping by 1 per cycle → `wr_en` on T+4…T+7, addresses 0…3, data = ramp values sampled at T+3…T+6, `done` at T+8, `busy` on T+1…T+8.
- **Zero delay:** `delay`=0, `length`=2 → writes on T+1 and T+2, `done` at T+3.
- **Zero length:** `delay`=5, `length`=0 → no `wr_en`, `done` at T+1, `busy` for 1 cycle.
- **Overlapping triggers:** with `delay`=2, `length`=8, pulse `trig` at T, T+5 and at the `done` cycle → only one window runs; `lost_cnt`=2 with the macro defined; an otherwise identical window with the macro undefined produces identical writes.
- **Reset mid-window:** assert `rstb`=0 during `CAPTURE` → `wr_en`, `busy`, `done` and `wr_addr` go to 0 immediately; after release a new `trig` starts at address 0.
- **Saturation:** hold a long window (`length`=1023) and issue 300 `trig` pulses during it → `lost_cnt` stops at 255.

Source files
------------

// File: rtl/adc_capture_window_pkg.sv
// rtl/adc_capture_window_pkg.sv - shared ADC-unit types, default widths and constants
package adc_capture_window_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 10;
    localparam int DLY_W_DEF  = 8;

    localparam logic [7:0] LOST_SAT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

endpackage

// File: rtl/adc_capture_window_win_counter.sv
// rtl/adc_capture_window_win_counter.sv - loadable down-counter with terminal-count flag
module adc_win_counter
    import adc_capture_window_pkg::*;
#(
    parameter int W = DLY_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the last counted cycle so the owner can change state on this edge.
    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/adc_capture_window.sv
// rtl/adc_capture_window.sv - trigger-started delay/capture sequencer; ADC_CAPTURE_LOST_CNT_EN adds lost_cnt
module adc_capture_window
    import adc_capture_window_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DLY_W  = DLY_W_DEF
) (
    input  logic              clk1,
    input  logic              rstb,
    input  logic              trig,
    input  logic [DLY_W-1:0]  delay,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] adc_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
`ifdef ADC_CAPTURE_LOST_CNT_EN
    ,
    output logic [7:0]        lost_cnt
`endif
);

    cap_state_e        st_q, st_d;
    logic              accept;
    logic              dly_tc, len_tc;
    logic              wr_go;
    logic [ADDR_W-1:0] idx_q, idx_d, widx;
    logic              wr_en_q, busy_q, done_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    always_comb begin
        st_d   = st_q;
        accept = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (trig) begin
                    accept = 1'b1;
                    if (length == '0) begin
                        st_d = ST_DONE;
                    end else if (delay != '0) begin
                        st_d = ST_DELAY;
                    end else begin
                        st_d = ST_CAPTURE;
                    end
                end
            end
            ST_DELAY: begin
                if (dly_tc) begin
                    st_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (len_tc) begin
                    st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so the first write lands
    // on the same edge that enters CAPTURE and the index restarts at 0.
    assign wr_go = (st_d == ST_CAPTURE);
    assign widx  = (st_q == ST_CAPTURE) ? idx_q : '0;
    assign idx_d = wr_go ? (widx + ADDR_W'(1)) : '0;

    adc_win_counter #(.W(DLY_W)) u_dly_cnt (
        .clk_i      (clk1),
        .rst_ni     (rstb),
        .load_i     (accept),
        .load_val_i (delay),
        .dec_i      (st_q == ST_DELAY),
        .tc_o       (dly_tc)
    );

    // The entry write is not counted here; CAPTURE ends when the count hits 1.
    adc_win_counter #(.W(ADDR_W)) u_len_cnt (
        .clk_i      (clk1),
        .rst_ni     (rstb),
        .load_i     (accept),
        .load_val_i (length),
        .dec_i      (st_q == ST_CAPTURE),
        .tc_o       (len_tc)
    );

    always_ff @(posedge clk1 or negedge rstb) begin
        if (!rstb) begin
            st_q      <= ST_IDLE;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            st_q    <= st_d;
            idx_q   <= idx_d;
            wr_en_q <= wr_go;
            busy_q  <= (st_d != ST_IDLE);
            done_q  <= (st_d == ST_DONE);
            if (wr_go) begin
                wr_addr_q <= widx;
                wr_data_q <= adc_data;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef ADC_CAPTURE_LOST_CNT_EN
    logic [7:0] lost_q;

    always_ff @(posedge clk1 or negedge rstb) begin
        if (!rstb) begin
            lost_q <= 8'd0;
        end else if (trig && (st_q != ST_IDLE) && (lost_q != LOST_SAT)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign lost_cnt = lost_q;
`endif

endmodule
